// File: rtl/instr_assembler_pkg.sv
// rtl/instr_assembler_pkg.sv - shared constants and state type for the instruction assembler
package instr_assembler_pkg;

  // Fetch/decode boundary filler word, driven whenever no instruction is presented
  localparam logic [15:0] NOP_WORD = 16'b0000111100000000;

  // Header bits that encode the number of extension words
  localparam int LEN_BIT_HI = 15;
  localparam int LEN_BIT_LO = 14;

  typedef enum logic {
    ST_HEAD = 1'b0,
    ST_EXT  = 1'b1
  } asm_state_e;

endpackage

// File: rtl/instr_len_decode.sv
// rtl/instr_len_decode.sv - header length bits to extension word count
module instr_len_decode #(
  parameter int EXT_MAX = 2
) (
  input  logic [1:0] len_bits,
  output logic [1:0] ext_cnt
);

  logic two_ext;

  // hi=0 -> 0, hi=1/lo=0 -> 1, hi=1/lo=1 -> 2 when two extensions are supported, else 1
  always_comb begin
    two_ext = (EXT_MAX >= 2) && len_bits[1] && len_bits[0];
    ext_cnt = {two_ext, len_bits[1] & ~two_ext};
  end

endmodule

// File: rtl/instr_assembler.sv
// rtl/instr_assembler.sv - collects header + extension words into whole instructions for ID
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int                 WORD_W  = 16,
  parameter int                 EXT_MAX = 2,
  parameter int                 PC_W    = 16,
  parameter logic [WORD_W-1:0]  NOP     = NOP_WORD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         word_in,
  input  logic [PC_W-1:0]           pc_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         instr_out,
  output logic [EXT_MAX*WORD_W-1:0] imm_out,
  output logic [1:0]                ext_cnt,
  output logic [PC_W-1:0]           pc_out
);

  localparam int IMM_W = EXT_MAX * WORD_W;

  asm_state_e         state_q, state_d;
  logic [1:0]         ext_n_q, ext_n_d;
  logic [1:0]         ext_left_q, ext_left_d;
  logic [WORD_W-1:0]  hdr_q, hdr_d;
  logic [PC_W-1:0]    hdr_pc_q, hdr_pc_d;
  logic [IMM_W-1:0]   col_q, col_d;

  logic               out_valid_q, out_valid_d;
  logic [WORD_W-1:0]  instr_q, instr_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  logic [1:0]         ext_cnt_q, ext_cnt_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;

  logic [1:0]         hdr_ext;
  logic [1:0]         slot;
  logic [IMM_W-1:0]   col_next;
  logic               accept;

  instr_len_decode #(
    .EXT_MAX (EXT_MAX)
  ) u_len_decode (
    .len_bits (word_in[LEN_BIT_HI:LEN_BIT_LO]),
    .ext_cnt  (hdr_ext)
  );

  // The output register may take a new word whenever it is empty or being drained this cycle
  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign instr_out = instr_q;
  assign imm_out   = imm_q;
  assign ext_cnt   = ext_cnt_q;
  assign pc_out    = pc_out_q;

  // Next state: word collection, instruction completion, drain and flush
  always_comb begin
    state_d     = state_q;
    ext_n_d     = ext_n_q;
    ext_left_d  = ext_left_q;
    hdr_d       = hdr_q;
    hdr_pc_d    = hdr_pc_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    imm_d       = imm_q;
    ext_cnt_d   = ext_cnt_q;
    pc_out_d    = pc_out_q;

    accept = in_valid && in_ready && !flush;
    slot   = ext_n_q - ext_left_q;

    // Drop the incoming word into its extension slot; other slots keep what was collected
    col_next = col_q;
    for (int i = 0; i < EXT_MAX; i++) begin
      if (slot == 2'(i)) begin
        col_next[i*WORD_W +: WORD_W] = word_in;
      end
    end

    // A consumed instruction leaves the output empty unless another completes this edge
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      instr_d     = NOP;
    end

    if (flush) begin
      state_d     = ST_HEAD;
      ext_left_d  = 2'd0;
      out_valid_d = 1'b0;
      instr_d     = NOP;
    end else if (accept) begin
      case (state_q)
        ST_HEAD: begin
          if (hdr_ext == 2'd0) begin
            out_valid_d = 1'b1;
            instr_d     = word_in;
            imm_d       = '0;
            ext_cnt_d   = 2'd0;
            pc_out_d    = pc_in;
          end else begin
            hdr_d      = word_in;
            hdr_pc_d   = pc_in;
            ext_n_d    = hdr_ext;
            ext_left_d = hdr_ext;
            col_d      = '0;
            state_d    = ST_EXT;
          end
        end
        ST_EXT: begin
          col_d      = col_next;
          ext_left_d = ext_left_q - 2'd1;
          if (ext_left_q == 2'd1) begin
            out_valid_d = 1'b1;
            instr_d     = hdr_q;
            imm_d       = col_next;
            ext_cnt_d   = ext_n_q;
            pc_out_d    = hdr_pc_q;
            state_d     = ST_HEAD;
          end
        end
        default: state_d = ST_HEAD;
      endcase
    end
  end

  // State, collect and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HEAD;
      ext_n_q     <= 2'd0;
      ext_left_q  <= 2'd0;
      hdr_q       <= '0;
      hdr_pc_q    <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      instr_q     <= NOP;
      imm_q       <= '0;
      ext_cnt_q   <= 2'd0;
      pc_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      ext_n_q     <= ext_n_d;
      ext_left_q  <= ext_left_d;
      hdr_q       <= hdr_d;
      hdr_pc_q    <= hdr_pc_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      imm_q       <= imm_d;
      ext_cnt_q   <= ext_cnt_d;
      pc_out_q    <= pc_out_d;
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// tb/tb_instr_assembler.sv - self-checking bench for instr_assembler, EXT_MAX=1 and EXT_MAX=2
module tb_instr_assembler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] word_in = 16'h0;
  logic [15:0] pc_in = 16'h0;
  logic        out_ready = 1'b0;

  logic        in_ready1, out_valid1;
  logic [15:0] instr1, imm1, pc1;
  logic [1:0]  cnt1;
  logic        in_ready2, out_valid2;
  logic [15:0] instr2, pc2;
  logic [31:0] imm2;
  logic [1:0]  cnt2;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  instr_assembler #(.WORD_W(16), .EXT_MAX(1), .PC_W(16)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .word_in(word_in), .pc_in(pc_in), .out_valid(out_valid1), .out_ready(out_ready),
    .instr_out(instr1), .imm_out(imm1), .ext_cnt(cnt1), .pc_out(pc1)
  );

  instr_assembler #(.WORD_W(16), .EXT_MAX(2), .PC_W(16)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .word_in(word_in), .pc_in(pc_in), .out_valid(out_valid2), .out_ready(out_ready),
    .instr_out(instr2), .imm_out(imm2), .ext_cnt(cnt2), .pc_out(pc2)
  );

  // Reference model state, index 0 = EXT_MAX 1, index 1 = EXT_MAX 2
  logic [15:0] part   [2][3];
  int          part_n [2];
  logic [15:0] part_pc[2];
  logic        m_valid[2];
  logic [15:0] m_instr[2];
  logic [31:0] m_imm  [2];
  logic [1:0]  m_cnt  [2];
  logic [15:0] m_pc   [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic int ext_of(input logic [15:0] w, input int emax);
    if (!w[15]) return 0;
    if (emax == 2 && w[14]) return 2;
    return 1;
  endfunction

  task automatic model_clear(input int d);
    part_n[d]  = 0;
    m_valid[d] = 1'b0;
  endtask

  // Compare one DUT against its model, then advance the model by the upcoming edge
  task automatic check_dut(input int d, input logic ov, input logic ir, input logic [15:0] ins,
                           input logic [31:0] imm, input logic [1:0] cnt, input logic [15:0] pc,
                           input logic rst_now);
    logic exp_ready;
    logic acc;
    logic done;
    int   need;
    string s;
    s = (d == 0) ? "e1" : "e2";
    exp_ready = !m_valid[d] || out_ready;
    chk({s, "_out_valid"}, {31'b0, ov}, {31'b0, m_valid[d]});
    chk({s, "_in_ready"}, {31'b0, ir}, {31'b0, exp_ready});
    if (m_valid[d]) begin
      chk({s, "_instr"}, {16'b0, ins}, {16'b0, m_instr[d]});
      chk({s, "_imm"}, imm, m_imm[d]);
      chk({s, "_ext_cnt"}, {30'b0, cnt}, {30'b0, m_cnt[d]});
      chk({s, "_pc"}, {16'b0, pc}, {16'b0, m_pc[d]});
    end else begin
      chk({s, "_nop"}, {16'b0, ins}, 32'h0000_0F00);
    end
    if (rst_now) return;
    if (flush) begin
      model_clear(d);
      return;
    end
    acc  = in_valid && exp_ready;
    done = 1'b0;
    if (acc) begin
      if (part_n[d] == 0) part_pc[d] = pc_in;
      part[d][part_n[d]] = word_in;
      part_n[d]++;
      need = 1 + ext_of(part[d][0], d + 1);
      if (part_n[d] == need) begin
        m_instr[d] = part[d][0];
        m_imm[d]   = 32'h0;
        for (int k = 1; k < need; k++) m_imm[d] = m_imm[d] | (32'(part[d][k]) << (16 * (k - 1)));
        m_cnt[d]   = 2'(need - 1);
        m_pc[d]    = part_pc[d];
        m_valid[d] = 1'b1;
        part_n[d]  = 0;
        done       = 1'b1;
      end
    end
    if (!done && m_valid[d] && out_ready) m_valid[d] = 1'b0;
  endtask

  task automatic step(input logic r, input logic iv, input logic [15:0] w, input logic [15:0] p,
                      input logic ordy, input logic fl);
    reset = r; in_valid = iv; word_in = w; pc_in = p; out_ready = ordy; flush = fl;
    @(negedge clk);
    if (r) begin
      model_clear(0);
      model_clear(1);
    end
    check_dut(0, out_valid1, in_ready1, instr1, {16'b0, imm1}, cnt1, pc1, r);
    check_dut(1, out_valid2, in_ready2, instr2, imm2, cnt2, pc2, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    model_clear(0);
    model_clear(1);
    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("rst_out_valid1", {31'b0, out_valid1}, 32'd0);
    chk("rst_instr1", {16'b0, instr1}, 32'h0F00);
    chk("rst_in_ready1", {31'b0, in_ready1}, 32'd1);
    chk("rst_out_valid2", {31'b0, out_valid2}, 32'd0);
    chk("rst_instr2", {16'b0, instr2}, 32'h0F00);
    chk("rst_imm2", imm2, 32'd0);

    // back-to-back 0-ext instructions
    step(1'b0, 1'b1, 16'h0123, 16'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h0456, 16'd1, 1'b1, 1'b0);
    idle(2);

    // two-extension instruction
    step(1'b0, 1'b1, 16'hC012, 16'd2, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'hAAAA, 16'd3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h5555, 16'd4, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("e2_c012_instr", {16'b0, instr2}, 32'hC012);
    chk("e2_c012_imm", imm2, 32'h5555_AAAA);
    chk("e2_c012_cnt", {30'b0, cnt2}, 32'd2);
    idle(2);

    // single-extension legacy format, then discard the partial left in the EXT_MAX=2 copy
    step(1'b0, 1'b1, 16'hC012, 16'd8, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 16'd9, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("e1_c012_imm", {16'b0, imm1}, 32'h1234);
    chk("e1_c012_cnt", {30'b0, cnt1}, 32'd1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    idle(1);

    // stall with a full output for 5 cycles, then release
    step(1'b0, 1'b1, 16'h0011, 16'd20, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0022, 16'd21, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0022, 16'd21, 1'b1, 1'b0);
    idle(2);

    // flush a partial instruction
    step(1'b0, 1'b1, 16'h8001, 16'd30, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h7777, 16'd31, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h0042, 16'd32, 1'b1, 1'b0);
    idle(2);

    // randomized traffic, with one reset in the middle of the stream
    for (int i = 0; i < 600; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15] = 1'b0;
      step((i == 300), ($urandom_range(0, 3) != 0), w, 16'(i + 100),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
